// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The controller takes the slave modport; whoever drives the stage fields takes master.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic [4:0]       idex_rs1;
  logic [4:0]       idex_rs2;
  logic [4:0]       idex_rd;
  logic             idex_memRead;
  logic [4:0]       exmem_rd;
  logic             exmem_regWrite;
  logic             exmem_branchTaken;
  logic [4:0]       memwb_rd;
  logic             memwb_regWrite;
  // Handshake: the MEM stage holds mem_req high for its load/store until a cycle
  // in which mem_ready is also high; that cycle completes the access.
  logic             mem_req;
  logic             mem_ready;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_bubble;
  logic             pc_src;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles;
  logic [1:0]       state_dbg;
  logic [7:0]       wait_cnt_dbg;

  modport master (
    output ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, idex_memRead,
           exmem_rd, exmem_regWrite, exmem_branchTaken, memwb_rd, memwb_regWrite,
           mem_req, mem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush,
           exmem_flush, memwb_bubble, pc_src, forwardA, forwardB, mem_fault,
           stall_cycles, state_dbg, wait_cnt_dbg
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, idex_memRead,
           exmem_rd, exmem_regWrite, exmem_branchTaken, memwb_rd, memwb_regWrite,
           mem_req, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush,
           exmem_flush, memwb_bubble, pc_src, forwardA, forwardB, mem_fault,
           stall_cycles, state_dbg, wait_cnt_dbg
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, branch flushes,
// operand forwarding and data-memory wait handling with a timeout fault.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic             fault_set;
  logic             mem_fault_q;
  logic [CNT_W-1:0] stall_q;
  logic             mem_stall;
  logic             branch;
  logic             load_use;

  always_comb begin
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    fault_set        = 1'b0;
    mem_stall        = 1'b0;
    hz.pc_write      = 1'b1;
    hz.ifid_write    = 1'b1;
    hz.idex_write    = 1'b1;
    hz.exmem_write   = 1'b1;
    hz.ifid_flush    = 1'b0;
    hz.idex_flush    = 1'b0;
    hz.exmem_flush   = 1'b0;
    hz.memwb_bubble  = 1'b0;
    hz.pc_src        = 1'b0;

    case (state)
      RUN: begin
        mem_stall = hz.mem_req && !hz.mem_ready;
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        mem_stall = !hz.mem_ready;
        if (mem_stall) begin
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = HALT;
            fault_set = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end
      end
      default: begin
        // HALT freezes the pipe exactly like an unfinished memory access.
        mem_stall = 1'b1;
        state_nxt = HALT;
      end
    endcase

    branch   = !mem_stall && hz.exmem_branchTaken;
    load_use = !mem_stall && !branch && hz.idex_memRead && (hz.idex_rd != 5'd0) &&
               ((hz.idex_rd == hz.ifid_rs1) || (hz.idex_rd == hz.ifid_rs2));

    if (reset) begin
      hz.pc_write     = 1'b0;
      hz.ifid_flush   = 1'b1;
      hz.idex_flush   = 1'b1;
      hz.exmem_flush  = 1'b1;
      hz.memwb_bubble = 1'b1;
    end else if (mem_stall) begin
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.idex_write   = 1'b0;
      hz.exmem_write  = 1'b0;
      hz.memwb_bubble = 1'b1;
    end else if (branch) begin
      hz.pc_src       = 1'b1;
      hz.ifid_flush   = 1'b1;
      hz.idex_flush   = 1'b1;
      hz.exmem_flush  = 1'b1;
    end else if (load_use) begin
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.idex_flush   = 1'b1;
    end
  end

  // EX/MEM has the younger result, so it wins over MEM/WB.
  always_comb begin
    hz.forwardA = 2'b00;
    hz.forwardB = 2'b00;
    if (!reset) begin
      if (hz.exmem_regWrite && hz.exmem_rd != 5'd0 && hz.exmem_rd == hz.idex_rs1)
        hz.forwardA = 2'b10;
      else if (hz.memwb_regWrite && hz.memwb_rd != 5'd0 && hz.memwb_rd == hz.idex_rs1)
        hz.forwardA = 2'b01;
      if (hz.exmem_regWrite && hz.exmem_rd != 5'd0 && hz.exmem_rd == hz.idex_rs2)
        hz.forwardB = 2'b10;
      else if (hz.memwb_regWrite && hz.memwb_rd != 5'd0 && hz.memwb_rd == hz.idex_rs2)
        hz.forwardB = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_fault_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (fault_set)
        mem_fault_q <= 1'b1;
      if (!hz.pc_write && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign hz.mem_fault    = mem_fault_q;
  assign hz.stall_cycles = stall_q;
  assign hz.state_dbg    = state;
  assign hz.wait_cnt_dbg = wait_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written memory-wait/timeout/reset
// sequences, and randomized cycles against a stall-counting reference model.
module tb_pipe_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;
  localparam int STALL_MAX  = (1 << TB_CNT_W) - 1;

  // {pc_w, ifid_w, idex_w, exmem_w, ifid_fl, idex_fl, exmem_fl, bubble, pc_src, fA, fB}
  localparam logic [12:0] V_DEF = 13'b1111_000_0_0_00_00;
  localparam logic [12:0] V_LU  = 13'b0011_010_0_0_00_00;
  localparam logic [12:0] V_BR  = 13'b1111_111_0_1_00_00;
  localparam logic [12:0] V_FRZ = 13'b0000_000_1_0_00_00;
  localparam logic [12:0] V_RST = 13'b0111_111_1_0_00_00;

  typedef struct packed {
    logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd;
    logic       idex_memRead;
    logic [4:0] exmem_rd;
    logic       exmem_regWrite, exmem_branchTaken;
    logic [4:0] memwb_rd;
    logic       memwb_regWrite, mem_req, mem_ready;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [12:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [12:0] exp_q[$];

  int m_wait;
  bit m_halt;
  bit m_fault;
  int m_stall;

  pipe_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [12:0] dut_out();
    return {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write,
            hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_bubble,
            hz.pc_src, hz.forwardA, hz.forwardB};
  endfunction

  function automatic in_t mk_in(logic [4:0] f_rs1, logic [4:0] f_rs2, logic [4:0] x_rs1,
                                logic [4:0] x_rs2, logic [4:0] x_rd, logic x_mr,
                                logic [4:0] e_rd, logic e_rw, logic e_br,
                                logic [4:0] w_rd, logic w_rw, logic mreq, logic mrdy);
    in_t r;
    r.ifid_rs1 = f_rs1;  r.ifid_rs2 = f_rs2;
    r.idex_rs1 = x_rs1;  r.idex_rs2 = x_rs2;  r.idex_rd = x_rd;  r.idex_memRead = x_mr;
    r.exmem_rd = e_rd;   r.exmem_regWrite = e_rw;  r.exmem_branchTaken = e_br;
    r.memwb_rd = w_rd;   r.memwb_regWrite = w_rw;
    r.mem_req  = mreq;   r.mem_ready = mrdy;
    return r;
  endfunction

  // driver tasks
  task automatic apply(in_t i, bit rst);
    reset                = rst;
    hz.ifid_rs1          = i.ifid_rs1;
    hz.ifid_rs2          = i.ifid_rs2;
    hz.idex_rs1          = i.idex_rs1;
    hz.idex_rs2          = i.idex_rs2;
    hz.idex_rd           = i.idex_rd;
    hz.idex_memRead      = i.idex_memRead;
    hz.exmem_rd          = i.exmem_rd;
    hz.exmem_regWrite    = i.exmem_regWrite;
    hz.exmem_branchTaken = i.exmem_branchTaken;
    hz.memwb_rd          = i.memwb_rd;
    hz.memwb_regWrite    = i.memwb_regWrite;
    hz.mem_req           = i.mem_req;
    hz.mem_ready         = i.mem_ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply('0, 1'b1);
    tick();
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: counts consecutive frozen cycles, faults once TIMEOUT are seen
  function automatic logic [1:0] fwd_sel(logic [4:0] rs, in_t i);
    if (i.exmem_regWrite && i.exmem_rd != 0 && i.exmem_rd == rs) return 2'b10;
    if (i.memwb_regWrite && i.memwb_rd != 0 && i.memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit model_frozen(in_t i);
    return m_halt || (!i.mem_ready && (i.mem_req || m_wait > 0));
  endfunction

  function automatic logic [12:0] model_out(in_t i, bit rst);
    logic [12:0] fw;
    bit          lu;
    if (rst) return V_RST;
    fw = {9'b0, fwd_sel(i.idex_rs1, i), fwd_sel(i.idex_rs2, i)};
    lu = i.idex_memRead && i.idex_rd != 0 &&
         (i.idex_rd == i.ifid_rs1 || i.idex_rd == i.ifid_rs2);
    if (model_frozen(i))     return V_FRZ | fw;
    if (i.exmem_branchTaken) return V_BR | fw;
    if (lu)                  return V_LU | fw;
    return V_DEF | fw;
  endfunction

  task automatic model_update(in_t i, bit rst, logic [12:0] exp);
    if (rst) begin
      m_wait = 0; m_halt = 0; m_fault = 0; m_stall = 0;
    end else begin
      if (!exp[12] && m_stall < STALL_MAX) m_stall++;
      if (!m_halt) begin
        if (model_frozen(i)) begin
          m_wait++;
          if (m_wait == TB_TIMEOUT) begin
            m_halt  = 1;
            m_fault = 1;
          end
        end else begin
          m_wait = 0;
        end
      end
    end
  endtask

  vec_t tbl[13];
  in_t  s;

  initial begin
    n_checks = 0;
    n_errors = 0;

    tbl[0]  = '{"default",       mk_in(1,2,3,4,0,0, 0,0,0, 0,0, 0,1), V_DEF};
    tbl[1]  = '{"loaduse_rs2",   mk_in(1,5,0,0,5,1, 0,0,0, 0,0, 0,0), V_LU};
    tbl[2]  = '{"loaduse_rs1",   mk_in(9,2,0,0,9,1, 0,0,0, 0,0, 0,0), V_LU};
    tbl[3]  = '{"load_rd0",      mk_in(0,0,0,0,0,1, 0,0,0, 0,0, 0,0), V_DEF};
    tbl[4]  = '{"noload_match",  mk_in(5,5,0,0,5,0, 0,0,0, 0,0, 0,0), V_DEF};
    tbl[5]  = '{"fwdA_exmem",    mk_in(0,0,7,0,0,0, 7,1,0, 7,1, 0,0), V_DEF | 13'b0_1000};
    tbl[6]  = '{"fwdA_memwb",    mk_in(0,0,7,0,0,0, 0,1,0, 7,1, 0,0), V_DEF | 13'b0_0100};
    tbl[7]  = '{"fwdA_exmem_nw", mk_in(0,0,7,0,0,0, 7,0,0, 7,1, 0,0), V_DEF | 13'b0_0100};
    tbl[8]  = '{"fwdB_memwb",    mk_in(0,0,0,3,0,0, 0,0,0, 3,1, 0,0), V_DEF | 13'b0_0001};
    tbl[9]  = '{"fwdB_exmem",    mk_in(0,0,0,9,0,0, 9,1,0, 9,1, 0,0), V_DEF | 13'b0_0010};
    tbl[10] = '{"branch",        mk_in(0,0,0,0,0,0, 0,0,1, 0,0, 0,1), V_BR};
    tbl[11] = '{"branch_lu",     mk_in(5,0,0,0,5,1, 0,0,1, 0,0, 0,0), V_BR};
    tbl[12] = '{"mem_done",      mk_in(0,0,0,0,0,0, 0,0,0, 0,0, 1,1), V_DEF};

    // reset-time outputs with a forwarding match present
    apply(mk_in(0,0,7,7,0,0, 7,1,0, 7,1, 1,0), 1'b1);
    check("reset_outputs", 32'(dut_out()), 32'(V_RST));
    tick();
    check("reset_state", 32'(hz.state_dbg), 32'd0);
    check("reset_wait", 32'(hz.wait_cnt_dbg), 32'd0);
    check("reset_fault", 32'(hz.mem_fault), 32'd0);
    check("reset_stall", 32'(hz.stall_cycles), 32'd0);

    // vector table; stall counter follows the number of pc_write=0 vectors
    begin
      int exp_stall;
      exp_stall = 0;
      foreach (tbl[k]) begin
        apply(tbl[k].in, 1'b0);
        check(tbl[k].name, 32'(dut_out()), 32'(tbl[k].exp));
        if (!tbl[k].exp[12]) exp_stall++;
        tick();
        check({tbl[k].name, "_stall"}, 32'(hz.stall_cycles), 32'(exp_stall));
        check({tbl[k].name, "_state"}, 32'(hz.state_dbg), 32'd0);
      end
    end

    // memory wait of 3 cycles with a branch pending throughout
    do_reset();
    s = '0; s.mem_req = 1; s.exmem_branchTaken = 1;
    for (int k = 0; k < 3; k++) begin
      apply(s, 1'b0);
      check("memwait_frozen", 32'(dut_out()), 32'(V_FRZ));
      tick();
      check("memwait_cnt", 32'(hz.wait_cnt_dbg), 32'(k + 1));
    end
    s.mem_ready = 1;
    apply(s, 1'b0);
    check("memwait_branch", 32'(dut_out()), 32'(V_BR));
    tick();
    check("memwait_state", 32'(hz.state_dbg), 32'd0);
    check("memwait_cnt0", 32'(hz.wait_cnt_dbg), 32'd0);
    check("memwait_stall", 32'(hz.stall_cycles), 32'd3);

    // timeout into HALT, HALT ignores mem_ready, stall counter saturates
    do_reset();
    s = '0; s.mem_req = 1;
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      apply(s, 1'b0);
      check("timeout_frozen", 32'(dut_out()), 32'(V_FRZ));
      tick();
      check("timeout_fault", 32'(hz.mem_fault), 32'(k == TB_TIMEOUT - 1));
    end
    check("timeout_halt", 32'(hz.state_dbg), 32'd2);
    s.mem_ready = 1; s.mem_req = 0; s.exmem_branchTaken = 1;
    for (int k = 0; k < 20; k++) begin
      apply(s, 1'b0);
      check("halt_frozen", 32'(dut_out()), 32'(V_FRZ));
      tick();
      check("halt_state", 32'(hz.state_dbg), 32'd2);
    end
    check("halt_stall_sat", 32'(hz.stall_cycles), 32'(STALL_MAX));
    check("halt_fault", 32'(hz.mem_fault), 32'd1);
    apply(mk_in(0,0,7,7,0,0, 7,1,1, 7,1, 0,1), 1'b1);
    check("halt_reset_out", 32'(dut_out()), 32'(V_RST));
    tick();
    check("halt_reset_state", 32'(hz.state_dbg), 32'd0);
    check("halt_reset_fault", 32'(hz.mem_fault), 32'd0);
    check("halt_reset_stall", 32'(hz.stall_cycles), 32'd0);

    // reset during MEM_WAIT
    s = '0; s.mem_req = 1;
    apply(s, 1'b0);
    tick();
    check("mw_enter_state", 32'(hz.state_dbg), 32'd1);
    check("mw_enter_cnt", 32'(hz.wait_cnt_dbg), 32'd1);
    apply(s, 1'b1);
    check("mw_reset_out", 32'(dut_out()), 32'(V_RST));
    tick();
    check("mw_reset_state", 32'(hz.state_dbg), 32'd0);
    check("mw_reset_cnt", 32'(hz.wait_cnt_dbg), 32'd0);

    // randomized cycles against the reference model
    do_reset();
    m_wait = 0; m_halt = 0; m_fault = 0; m_stall = 0;
    for (int n = 0; n < 600; n++) begin
      in_t         r;
      bit          rst;
      logic [12:0] exp;
      r.ifid_rs1          = 5'($urandom_range(0, 3));
      r.ifid_rs2          = 5'($urandom_range(0, 3));
      r.idex_rs1          = 5'($urandom_range(0, 3));
      r.idex_rs2          = 5'($urandom_range(0, 3));
      r.idex_rd           = 5'($urandom_range(0, 3));
      r.idex_memRead      = 1'($urandom_range(0, 1));
      r.exmem_rd          = 5'($urandom_range(0, 3));
      r.exmem_regWrite    = 1'($urandom_range(0, 1));
      r.exmem_branchTaken = ($urandom_range(0, 3) == 0);
      r.memwb_rd          = 5'($urandom_range(0, 3));
      r.memwb_regWrite    = 1'($urandom_range(0, 1));
      r.mem_req           = ($urandom_range(0, 9) < 3);
      r.mem_ready         = ($urandom_range(0, 9) > 3);
      rst                 = ($urandom_range(0, 39) == 0);
      apply(r, rst);
      exp_q.push_back(model_out(r, rst));
      exp = exp_q.pop_front();
      check("rnd_outputs", 32'(dut_out()), 32'(exp));
      check("rnd_fault", 32'(hz.mem_fault), 32'(m_fault));
      check("rnd_stall", 32'(hz.stall_cycles), 32'(m_stall));
      model_update(r, rst, exp);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
